// File: rtl/mdu_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit:
// opcodes, engine states, iteration count and an opcode predicate.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MFHI  = 3'd4,
    OP_MFLO  = 3'd5,
    OP_MTHI  = 3'd6,
    OP_MTLO  = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mdu_state_e;

  localparam int ITER = 32;

  // The four iterative ops occupy the lower half of the opcode space.
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, shift the quotient bit in.
module mdu_divider #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem,
  input  logic [DATA_W-1:0] quo,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_next,
  output logic [DATA_W-1:0] quo_next
);

  logic [DATA_W:0] partial;
  logic            fits;

  // quo holds the not-yet-consumed dividend bits at the top and the
  // quotient bits built so far at the bottom.
  assign partial  = {rem, quo[DATA_W-1]};
  assign fits     = (partial >= {1'b0, divisor});
  assign rem_next = fits ? DATA_W'(partial - {1'b0, divisor}) : partial[DATA_W-1:0];
  assign quo_next = {quo[DATA_W-2:0], fits};

endmodule

// File: rtl/exe_mdu.sv
// Execute-stage multiply/divide unit: 32-step iterative MULT/DIV engine with
// sign fixup, architectural HI/LO and single-cycle MFHI/MFLO/MTHI/MTLO.
module exe_mdu #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              flush,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] busA,
  input  logic [DATA_W-1:0] busB,
  output logic              stall,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out
);

  import mdu_pkg::*;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

  mdu_state_e          state;
  mdu_op_e             op_e;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] acc;      // MULT: {partial product, multiplier}; DIV: {remainder, dividend/quotient}
  logic [DATA_W-1:0]   opnd;     // MULT: multiplicand magnitude; DIV: divisor magnitude
  logic [DATA_W-1:0]   hi, lo;
  logic                is_div, neg_a, neg_b, div_zero;

  logic                signed_op, a_neg_in, b_neg_in, accept;
  logic [DATA_W-1:0]   a_mag, b_mag;
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] mul_next, prod_fix;
  logic [DATA_W-1:0]   div_rem, div_quo, quo_fix, rem_fix;

  assign op_e      = mdu_op_e'(op);
  assign accept    = start && !flush;
  assign signed_op = (op_e == OP_MULT) || (op_e == OP_DIV);
  assign a_neg_in  = signed_op && busA[DATA_W-1];
  assign b_neg_in  = signed_op && busB[DATA_W-1];
  assign a_mag     = a_neg_in ? -busA : busA;
  assign b_mag     = b_neg_in ? -busB : busB;

  // Shift-add step: add the multiplicand into the upper half when the current
  // multiplier bit is set, then shift the whole accumulator right.
  assign mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_next = {mul_sum, acc[DATA_W-1:1]};

  mdu_divider #(.DATA_W(DATA_W)) u_divider (
    .rem      (acc[2*DATA_W-1:DATA_W]),
    .quo      (acc[DATA_W-1:0]),
    .divisor  (opnd),
    .rem_next (div_rem),
    .quo_next (div_quo)
  );

  // Remainder follows the dividend's sign; this also makes HI = busA on a
  // divide by zero, where the raw remainder equals |busA|.
  assign prod_fix = (neg_a ^ neg_b) ? -acc : acc;
  assign quo_fix  = div_zero ? '1 :
                    ((neg_a ^ neg_b) ? -acc[DATA_W-1:0] : acc[DATA_W-1:0]);
  assign rem_fix  = neg_a ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];

  assign stall  = (state != IDLE) || (accept && is_muldiv(op));
  assign busy   = (state != IDLE);
  assign hi_out = hi;
  assign lo_out = lo;

  // NOTE: every output of an always_comb gets a default first so no path
  // leaves it unassigned and infers a latch.
  always_comb begin
    rdata = '0;
    if (op_e == OP_MFHI)      rdata = hi;
    else if (op_e == OP_MFLO) rdata = lo;
  end

  // NOTE: state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      hi       <= '0;
      lo       <= '0;
      is_div   <= 1'b0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      div_zero <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_muldiv(op)) begin
              is_div   <= op[1];
              neg_a    <= a_neg_in;
              neg_b    <= b_neg_in;
              div_zero <= (busB == '0);
              opnd     <= op[1] ? b_mag : a_mag;
              acc      <= {{DATA_W{1'b0}}, (op[1] ? a_mag : b_mag)};
              cnt      <= '0;
              state    <= RUN;
            end else if (op_e == OP_MTHI) begin
              hi <= busA;
            end else if (op_e == OP_MTLO) begin
              lo <= busA;
            end
          end
        end
        RUN: begin
          if (flush) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            acc <= is_div ? {div_rem, div_quo} : mul_next;
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= FIX;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        FIX: begin
          if (!flush) begin
            if (is_div) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              hi <= prod_fix[2*DATA_W-1:DATA_W];
              lo <= prod_fix[DATA_W-1:0];
            end
            done <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exe_mdu.sv
// Self-checking bench for exe_mdu: directed corner cases plus randomized
// MULT/DIV/MT traffic against an arithmetic HI/LO reference model.
module tb_exe_mdu;

  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [2:0]  op;
  logic [31:0] busA, busB;
  logic        stall, busy, done;
  logic [31:0] rdata, hi_out, lo_out;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  exe_mdu #(.DATA_W(32), .CNT_W(6)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .flush  (flush),
    .op     (op),
    .busA   (busA),
    .busB   (busB),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .rdata  (rdata),
    .hi_out (hi_out),
    .lo_out (lo_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference result as {HI, LO}, straight from the arithmetic definitions.
  function automatic logic [63:0] ref_muldiv(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
    longint sa, sb, p;
    int     ia, ib;
    logic [63:0] r;
    r = '0;
    case (o)
      OP_MULT: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = sa * sb;
        r  = p;
      end
      OP_MULTU: r = {32'b0, a} * {32'b0, b};
      OP_DIV: begin
        if (b == 32'h0)                                  r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
        else begin
          ia = $signed(a);
          ib = $signed(b);
          r  = {32'(ia % ib), 32'(ia / ib)};
        end
      end
      default: begin
        if (b == 32'h0) r = {a, 32'hFFFF_FFFF};
        else            r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  // Issue one MULT/DIV, then present nxt_op/nxt_start while stalled and
  // check latency, stall length, done pulse and the HI/LO result.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] nxt_op, input logic nxt_start);
    logic [63:0] exp;
    int          stalls;
    logic        seen;
    exp = ref_muldiv(o, a, b);
    @(negedge clk);
    start = 1'b1; flush = 1'b0; op = o; busA = a; busB = b;
    #1 check("stall_issue", 64'(stall), 64'd1);
    stalls = 1;
    seen   = 1'b0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = nxt_start;
        op    = nxt_op;
      end
      #1;
      if (c == 1) check("busy_run", 64'(busy), 64'd1);
      if (done) begin
        seen = 1'b1;
        check("done_cycle", 64'(c), 64'd34);
        check("stall_at_done", 64'(stall), 64'd0);
        check("hi_result", 64'(hi_out), 64'(exp[63:32]));
        check("lo_result", 64'(lo_out), 64'(exp[31:0]));
        if (nxt_start && nxt_op == OP_MFHI) check("rdata_mfhi", 64'(rdata), 64'(exp[63:32]));
      end else if (stall) begin
        stalls++;
      end
    end
    check("done_seen", 64'(seen), 64'd1);
    check("stall_cycles", 64'(stalls), 64'd34);
    hi_m = exp[63:32];
    lo_m = exp[31:0];
    @(negedge clk);
    start = 1'b0;
    #1 check("done_one_cycle", 64'(done), 64'd0);
  endtask

  task automatic move_to(input logic [2:0] o, input logic [31:0] v);
    @(negedge clk);
    start = 1'b1; flush = 1'b0; op = o; busA = v;
    #1 check("mt_no_stall", 64'(stall), 64'd0);
    if (o == OP_MTHI) hi_m = v;
    else              lo_m = v;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("mt_hi", 64'(hi_out), 64'(hi_m));
    check("mt_lo", 64'(lo_out), 64'(lo_m));
  endtask

  // Start a DIV, then kill it at cycle `at` by flush or by async reset.
  task automatic abort_div(input int at, input logic use_reset);
    int dones;
    @(negedge clk);
    start = 1'b1; flush = 1'b0; op = OP_DIV; busA = $urandom; busB = $urandom | 32'h1;
    @(negedge clk);
    start = 1'b0;
    repeat (at - 1) @(negedge clk);
    if (!use_reset) begin
      flush = 1'b1;
      #1 check("flush_busy_before", 64'(busy), 64'd1);
      @(negedge clk);
      flush = 1'b0;
      #1;
      check("flush_idle", 64'(busy), 64'd0);
      check("flush_stall", 64'(stall), 64'd0);
    end else begin
      #2 reset = 1'b1;
      #1;
      hi_m = '0;
      lo_m = '0;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_stall", 64'(stall), 64'd0);
      check("rst_rdata", 64'(rdata), 64'd0);
      @(negedge clk);
      reset = 1'b0;
    end
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort_no_done", 64'(dones), 64'd0);
    check("abort_hi", 64'(hi_out), 64'(hi_m));
    check("abort_lo", 64'(lo_out), 64'(lo_m));
  endtask

  initial begin
    logic [2:0]  o;
    logic [31:0] a, b;
    int          sel;

    reset = 1'b1; start = 1'b0; flush = 1'b0; op = OP_MFHI; busA = '0; busB = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_stall", 64'(stall), 64'd0);
    check("reset_hi", 64'(hi_out), 64'd0);
    check("reset_lo", 64'(lo_out), 64'd0);
    check("reset_rdata", 64'(rdata), 64'd0);
    reset = 1'b0;

    run_op(OP_MULT,  32'hFFFF_FFFE, 32'd3,         OP_MFLO, 1'b0);
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_MFLO, 1'b0);
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         OP_MFLO, 1'b0);
    run_op(OP_DIVU,  32'd7,         32'd0,         OP_MFLO, 1'b0);
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd0,         OP_MFLO, 1'b0);
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, OP_MFLO, 1'b0);

    @(negedge clk);
    start = 1'b1; op = OP_MFLO;
    #1;
    check("mflo_rdata", 64'(rdata), 64'h8000_0000);
    check("mflo_no_stall", 64'(stall), 64'd0);
    @(negedge clk);
    start = 1'b0;

    move_to(OP_MTHI, 32'h1234_5678);
    @(negedge clk);
    start = 1'b1; op = OP_MFHI;
    #1 check("mfhi_after_mthi", 64'(rdata), 64'h1234_5678);
    start = 1'b0;
    run_op(OP_DIV, 32'd100, 32'd7, OP_MFHI, 1'b1);

    // flush together with start in IDLE must be ignored entirely
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = OP_MULT; busA = 32'd5; busB = 32'd6;
    #1 check("flush_start_stall", 64'(stall), 64'd0);
    @(negedge clk);
    op = OP_MTLO; busA = 32'hDEAD_BEEF;
    #1 check("flush_start_busy", 64'(busy), 64'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1 check("flush_mtlo_ignored", 64'(lo_out), 64'(lo_m));

    abort_div(10, 1'b0);
    abort_div(20, 1'b1);

    for (int i = 0; i < 24; i++) begin
      o   = 3'($urandom_range(0, 3));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0)      b = '0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; o = OP_DIV; end
      else if (sel == 2) b = 32'($urandom_range(1, 15));
      else if (sel == 3) a = 32'($urandom_range(0, 255));
      run_op(o, a, b, (sel[0] ? OP_MFHI : OP_MFLO), 1'(sel[1]));
      if (sel >= 6) move_to((sel[0] ? OP_MTHI : OP_MTLO), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/exe_mdu.md
# exe_mdu

Execute-stage multiply/divide unit with architectural HI/LO registers. It consumes the decoded operation and operands latched by the ID/EXE pipeline register and runs MULT/MULTU/DIV/DIVU as an iterative 32-step engine. While it is busy it drives a stall to freeze IF/ID/EXE. It also serves MFHI/MFLO/MTHI/MTLO in a single cycle.

## Interface
- DATA_W, 32, operand and HI/LO width
- CNT_W, 6, iteration counter width, must hold DATA_W
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- start  in  1  valid MDU op from ID/EXE this cycle
- flush  in  1  abort in-flight op and ignore start (same role as the ID/EXE flush)
- op  in  3  MDU opcode (mdu_pkg encoding)
- busA  in  DATA_W  rs operand / dividend / multiplicand
- busB  in  DATA_W  rt operand / divisor / multiplier
- stall  out  1  hold upstream stages and ID/EXE; combinational
- busy  out  1  engine running (state != IDLE), registered
- done  out  1  one-cycle pulse after HI/LO are updated by MULT/DIV
- rdata  out  DATA_W  HI for MFHI, LO for MFLO, else 0; combinational
- hi_out, lo_out  out  DATA_W  current HI/LO

## Operation
- States: IDLE, RUN, FIX.
- IDLE + start + MULT/MULTU/DIV/DIVU (no flush):
  - latch operand magnitudes (signed ops) or raw values (unsigned), plus the sign flags
  - counter=0, go to RUN
- RUN, one step per cycle:
  - multiply: shift-add, 64-bit product accumulator
  - divide: restoring, 1 quotient bit per step
  - after step 32 (counter==31 at the edge), go to FIX
- FIX: apply sign correction, write HI/LO on the edge, go to IDLE, assert done the next cycle.
  - multiply: HI = product[63:32], LO = product[31:0]
  - divide: LO = quotient, HI = remainder; remainder takes the dividend's sign
- Divide by zero: runs full latency; LO=32'hFFFF_FFFF, HI=busA.
- Signed 32'h8000_0000 / 32'hFFFF_FFFF: LO=32'h8000_0000, HI=0.
- MTHI/MTLO in IDLE: HI (or LO) = busA on the next edge; no stall.
- MFHI/MFLO: rdata combinational from current HI/LO.
- MFHI/MFLO/MTHI/MTLO while busy: stall held until IDLE, then executed.
- start while RUN/FIX: ignored. Upstream is stalled, so it re-presents the op.
- flush in RUN/FIX: return to IDLE next edge, HI/LO unchanged, no done.
- flush with start in IDLE: start is ignored.
- Reset: state=IDLE, counter=0, HI=LO=0, accumulators=0, busy=0, done=0.
  - stall=0 while start is low; rdata follows HI/LO=0.
  - Reset mid-operation discards the result.

## Timing
- Cycle 0: start with a MULT/DIV op. stall=1 combinationally. Edge E0 enters RUN.
- Cycles 1–32: RUN, stall=1, busy=1.
- Cycle 33: FIX, stall=1. Edge E33 writes HI/LO.
- Cycle 34: IDLE, stall=0, done=1. The instruction advances at E34.
- Total stall: 34 cycles. Result is visible on hi_out/lo_out in cycle 34.
- stall = (state!=IDLE) | (state==IDLE & start & !flush & op is MULT/MULTU/DIV/DIVU).
  - In IDLE, MF*/MT* never stall.
- MTHI/MTLO latency is one edge.
- MFHI immediately after an MTHI sees the new value, provided the MTHI edge occurred first.

## Structure
- mdu_pkg holds:
  - op encodings: MULT=0, MULTU=1, DIV=2, DIVU=3, MFHI=4, MFLO=5, MTHI=6, MTLO=7
  - state encodings IDLE/RUN/FIX
  - ITER constant = 32
  - predicate function is_muldiv(op)
- One sub-module, mdu_divider: restoring divide step datapath (partial remainder, quotient shift).
- The multiply step, FSM, HI/LO and sign fixup stay in exe_mdu.

## Test plan
- MULT busA=32'hFFFF_FFFE (-2), busB=3 -> HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA; stall high 34 cycles; done in cycle 34.
- MULTU busA=32'hFFFF_FFFF, busB=32'hFFFF_FFFF -> HI=32'hFFFF_FFFE, LO=1.
- DIV busA=-7, busB=2 -> LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF. DIVU busA=7, busB=0 -> LO=32'hFFFF_FFFF, HI=7.
- DIV 32'h8000_0000 / 32'hFFFF_FFFF -> LO=32'h8000_0000, HI=0. Then MFLO -> rdata=32'h8000_0000 with no stall.
- MTHI busA=32'h1234_5678 -> hi_out=32'h1234_5678 next cycle. Then MFHI while a DIV is started -> stall holds until done, then rdata = the DIV remainder.
- DIV started, flush at cycle 10 -> IDLE at cycle 11, HI/LO unchanged, done never pulses. Repeat with async reset at cycle 20 -> all outputs at their reset values immediately.
